// File: rtl/mem_writeback.sv
// Memory-access / write-back stage: produces the register-file write port and
// performs loads/stores over a req/ack data-memory handshake with timeout.
module mem_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR,
  input  logic [31:0] ALU_in,
  input  logic [31:0] B_in,
  input  logic [31:0] PC,
  input  logic        valid_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [4:0]  WB_address,
  output logic [31:0] WB_data,
  output logic        misaligned,
  output logic        bus_error
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_f3, w_f3q;
  logic [4:0]    r_rd, w_rdq;
  logic [1:0]    r_lane, w_lane;

  logic          w_req, w_we;
  logic [31:0]   w_addr, w_wdata;
  logic [3:0]    w_be;
  logic [4:0]    w_wba;
  logic [31:0]   w_wbd;
  logic          w_mis, w_berr;

  logic [6:0]    w_op;
  logic [4:0]    w_rd;
  logic [2:0]    w_f3;
  logic          w_is_load, w_is_store, w_is_mem, w_aligned, w_hit;
  logic [3:0]    w_st_be;
  logic [31:0]   w_st_data;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic          w_unused;

  assign w_unused = ^IR[31:15];

  always_comb begin
    w_op       = IR[6:0];
    w_rd       = IR[11:7];
    w_f3       = IR[14:12];
    w_is_load  = valid_in && (w_op == OP_LOAD);
    w_is_store = valid_in && (w_op == OP_STORE);
    w_is_mem   = w_is_load || w_is_store;
    w_hit      = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES));

    case (w_f3[1:0])
      2'b00:   begin
        w_aligned = 1'b1;
        w_st_be   = 4'b0001 << ALU_in[1:0];
        w_st_data = {4{B_in[7:0]}};
      end
      2'b01:   begin
        w_aligned = ~ALU_in[0];
        w_st_be   = 4'b0011 << ALU_in[1:0];
        w_st_data = {2{B_in[15:0]}};
      end
      default: begin
        w_aligned = (ALU_in[1:0] == 2'b00);
        w_st_be   = 4'b1111;
        w_st_data = B_in;
      end
    endcase

    w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_f3q     = r_f3;
    w_rdq     = r_rd;
    w_lane    = r_lane;
    w_req     = mem_req;
    w_we      = mem_we;
    w_addr    = mem_addr;
    w_wdata   = mem_wdata;
    w_be      = mem_be;
    w_wba     = '0;
    w_wbd     = '0;
    w_mis     = 1'b0;
    w_berr    = 1'b0;
    stall_out = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_is_mem && w_aligned) begin
          // Held in stall until the WAIT cycle that acks or times out.
          stall_out = 1'b1;
          w_state   = S_WAIT;
          w_cnt     = CW'(1);
          w_f3q     = w_f3;
          w_rdq     = w_rd;
          w_lane    = ALU_in[1:0];
          w_req     = 1'b1;
          w_we      = w_is_store;
          w_addr    = {ALU_in[31:2], 2'b00};
          w_be      = w_is_store ? w_st_be : 4'b1111;
          w_wdata   = w_st_data;
        end else if (w_is_mem) begin
          w_mis = 1'b1;
        end else if (valid_in) begin
          case (w_op)
            OP_LUI, OP_AUIPC, OP_OP, OP_IMM: begin
              w_wba = w_rd;
              w_wbd = ALU_in;
            end
            OP_JAL, OP_JALR: begin
              w_wba = w_rd;
              w_wbd = PC + 32'd4;
            end
            default: ;
          endcase
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_req   = 1'b0;
          if (!mem_we) begin
            w_wba = r_rd;
            w_wbd = w_load;
          end
        end else if (w_hit) begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_req   = 1'b0;
          w_berr  = 1'b1;
        end else begin
          stall_out = 1'b1;
          w_cnt     = r_cnt + CW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_f3       <= '0;
      r_rd       <= '0;
      r_lane     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      WB_address <= '0;
      WB_data    <= '0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_f3       <= w_f3q;
      r_rd       <= w_rdq;
      r_lane     <= w_lane;
      mem_req    <= w_req;
      mem_we     <= w_we;
      mem_addr   <= w_addr;
      mem_wdata  <= w_wdata;
      mem_be     <= w_be;
      WB_address <= w_wba;
      WB_data    <= w_wbd;
      misaligned <= w_mis;
      bus_error  <= w_berr;
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Self-checking bench for mem_writeback: directed scenarios plus randomized
// instructions compared against a transaction-level reference model.
module tb_mem_writeback;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IR = '0, ALU_in = '0, B_in = '0, PC = '0, mem_rdata = '0;
  logic        valid_in = 1'b0, mem_ack = 1'b0;
  logic        stall_out, mem_req, mem_we, misaligned, bus_error;
  logic [31:0] mem_addr, mem_wdata, WB_data;
  logic [3:0]  mem_be;
  logic [4:0]  WB_address;

  int n_vec = 0;
  int n_miss = 0;

  mem_writeback #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .IR(IR), .ALU_in(ALU_in), .B_in(B_in), .PC(PC),
    .valid_in(valid_in), .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .WB_address(WB_address), .WB_data(WB_data),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall;
    int          req;
    logic        stable;
    logic        bad_wb;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        mis;
    logic        berr;
    logic        req_after;
  } obs_t;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [2:0] f3, input logic [16:0] hi);
    return {hi, f3, rd, op};
  endfunction

  // Whole-instruction reference: what the stage should do for one instruction
  // given the WAIT cycle index at which memory acks (-1 = never).
  function automatic obs_t model(input logic [31:0] ir, alu, b, pc, rdata, input int ack_at);
    obs_t e;
    int unsigned op, f3, rd, lane, nb;
    longint v;
    bit acked;
    op = ir[6:0]; rd = ir[11:7]; f3 = ir[14:12]; lane = alu % 4;
    e.stall = 0; e.req = 0; e.stable = 1; e.bad_wb = 0; e.addr = 0; e.we = 0;
    e.be = 0; e.wdata = 0; e.wba = 0; e.wbd = 0; e.mis = 0; e.berr = 0; e.req_after = 0;
    if (op == 3 || op == 35) begin
      nb = 1 << (f3 % 4);
      if (alu % nb != 0) e.mis = 1;
      else begin
        acked   = (ack_at >= 0) && (ack_at < TO);
        e.req   = acked ? ack_at + 1 : TO;
        e.stall = e.req;
        e.berr  = !acked;
        e.addr  = alu - lane;
        e.we    = (op == 35);
        if (op == 3) e.be = 4'hF;
        else if (nb == 1) begin e.be = 4'(1 << lane); e.wdata = (b % 256) * 32'h01010101; end
        else if (nb == 2) begin e.be = 4'(3 << lane); e.wdata = (b % 65536) * 32'h00010001; end
        else begin e.be = 4'hF; e.wdata = b; end
        if (op == 3 && acked) begin
          e.wba = 5'(rd);
          case (f3)
            0, 4: begin v = (rdata >> (8 * lane)) % 256;   if (f3 == 0 && v >= 128)   v -= 256;   end
            1, 5: begin v = (rdata >> (8 * lane)) % 65536; if (f3 == 1 && v >= 32768) v -= 65536; end
            default: v = rdata;
          endcase
          e.wbd = v[31:0];
        end
      end
    end else if (op inside {55, 23, 51, 19}) begin
      e.wba = 5'(rd); e.wbd = alu;
    end else if (op inside {111, 103}) begin
      e.wba = 5'(rd); e.wbd = pc + 4;
    end
    return e;
  endfunction

  // Presents one instruction, services the memory handshake, returns what was seen.
  task automatic run_instr(input logic [31:0] ir, alu, b, pc, rdata, input int ack_at,
                           output obs_t o);
    int guard;
    IR = ir; ALU_in = alu; B_in = b; PC = pc; valid_in = 1'b1;
    mem_ack = 1'b0; mem_rdata = $urandom;
    o.stall = 0; o.req = 0; o.stable = 1; o.bad_wb = 0;
    o.addr = 0; o.we = 0; o.be = 0; o.wdata = 0;
    guard = 0;
    #1;
    while (stall_out === 1'b1 && guard < 50) begin
      o.stall++; guard++;
      @(posedge clk); #1;
      if (WB_address !== 5'd0) o.bad_wb = 1'b1;
      if (mem_req === 1'b1) begin
        if (o.req == 0) begin
          o.addr = mem_addr; o.we = mem_we; o.be = mem_be; o.wdata = mem_wdata;
        end else if ({mem_addr, mem_we, mem_be, mem_wdata} !== {o.addr, o.we, o.be, o.wdata})
          o.stable = 1'b0;
        o.req++;
      end
      mem_ack   = (mem_req === 1'b1) && (o.req - 1 == ack_at);
      mem_rdata = mem_ack ? rdata : $urandom;
      #1;
    end
    @(posedge clk); #1;
    o.wba = WB_address; o.wbd = WB_data; o.mis = misaligned; o.berr = bus_error;
    o.req_after = mem_req;
    mem_ack = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ((|{mem_req, mem_we, mem_be, mem_addr, mem_wdata, WB_address, WB_data,
           misaligned, bus_error, stall_out}) !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_state got req=%b we=%b be=%h addr=%h wdata=%h wba=%0d wbd=%h mis=%b berr=%b stall=%b, expected all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, WB_address, WB_data,
               misaligned, bus_error, stall_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_jal;
    obs_t o;
    run_instr(mk(7'b1101111, 5'd1, 3'd0, 17'h0), 32'h0000_0500, 32'h0, 32'h0000_0100, 32'h0, -1, o);
    n_vec++;
    if ({o.wba, o.wbd} !== {5'd1, 32'h0000_0104}) begin
      n_miss++; $display("FAIL jal_wb got %0d/%h expected 1/00000104", o.wba, o.wbd);
    end
    n_vec++;
    if ({o.stall, o.req} !== {32'd0, 32'd0}) begin
      n_miss++; $display("FAIL jal_nostall got stall=%0d req=%0d expected 0/0", o.stall, o.req);
    end
  endtask

  task automatic test_lb_lbu;
    obs_t o;
    run_instr(mk(7'b0000011, 5'd5, 3'b000, 17'h0), 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_1234, 0, o);
    n_vec++;
    if ({o.addr, o.we, o.req, o.stall} !== {32'h0000_1000, 1'b0, 32'd1, 32'd1}) begin
      n_miss++; $display("FAIL lb_req got addr=%h we=%b req=%0d stall=%0d expected 00001000/0/1/1",
                         o.addr, o.we, o.req, o.stall);
    end
    n_vec++;
    if ({o.wba, o.wbd, o.req_after} !== {5'd5, 32'hFFFF_FF80, 1'b0}) begin
      n_miss++; $display("FAIL lb_data got %0d/%h req_after=%b expected 5/ffffff80/0", o.wba, o.wbd, o.req_after);
    end
    run_instr(mk(7'b0000011, 5'd5, 3'b100, 17'h0), 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_1234, 0, o);
    n_vec++;
    if ({o.wba, o.wbd} !== {5'd5, 32'h0000_0080}) begin
      n_miss++; $display("FAIL lbu_data got %0d/%h expected 5/00000080", o.wba, o.wbd);
    end
  endtask

  task automatic test_sh_delayed;
    obs_t o;
    run_instr(mk(7'b0100011, 5'd9, 3'b001, 17'h0), 32'h0000_2002, 32'h0000_ABCD, 32'h0, 32'h0, 3, o);
    n_vec++;
    if ({o.we, o.be, o.wdata, o.addr} !== {1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_2000}) begin
      n_miss++; $display("FAIL sh_fields got we=%b be=%b wdata=%h addr=%h expected 1/1100/abcdabcd/00002000",
                         o.we, o.be, o.wdata, o.addr);
    end
    n_vec++;
    if ({o.req, o.stall, o.stable, o.bad_wb} !== {32'd4, 32'd4, 1'b1, 1'b0}) begin
      n_miss++; $display("FAIL sh_hold got req=%0d stall=%0d stable=%b badwb=%b expected 4/4/1/0",
                         o.req, o.stall, o.stable, o.bad_wb);
    end
    n_vec++;
    if ({o.wba, o.berr, o.req_after} !== {5'd0, 1'b0, 1'b0}) begin
      n_miss++; $display("FAIL sh_wb got wba=%0d berr=%b req_after=%b expected 0/0/0", o.wba, o.berr, o.req_after);
    end
  endtask

  task automatic test_misaligned;
    obs_t o;
    run_instr(mk(7'b0000011, 5'd4, 3'b010, 17'h0), 32'h0000_1001, 32'h0, 32'h0, 32'h0, 0, o);
    n_vec++;
    if ({o.mis, o.wba, o.req, o.stall} !== {1'b1, 5'd0, 32'd0, 32'd0}) begin
      n_miss++; $display("FAIL misaligned_lw got mis=%b wba=%0d req=%0d stall=%0d expected 1/0/0/0",
                         o.mis, o.wba, o.req, o.stall);
    end
    @(posedge clk); #1;
    n_vec++;
    if (misaligned !== 1'b0) begin
      n_miss++; $display("FAIL misaligned_pulse got %b in second cycle expected 0", misaligned);
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_instr(mk(7'b0000011, 5'd6, 3'b010, 17'h0), 32'h0000_4000, 32'h0, 32'h0, 32'h0, -1, o);
    n_vec++;
    if ({o.req, o.stall, o.berr, o.wba, o.req_after} !== {32'd4, 32'd4, 1'b1, 5'd0, 1'b0}) begin
      n_miss++; $display("FAIL timeout got req=%0d stall=%0d berr=%b wba=%0d req_after=%b expected 4/4/1/0/0",
                         o.req, o.stall, o.berr, o.wba, o.req_after);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_vec++;
    if (stall_out !== 1'b0) begin
      n_miss++; $display("FAIL idle_ack_stall got %b expected 0", stall_out);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_vec++;
    if ({mem_req, WB_address, bus_error} !== {1'b0, 5'd0, 1'b0}) begin
      n_miss++; $display("FAIL idle_ack_ignored got req=%b wba=%0d berr=%b expected 0/0/0",
                         mem_req, WB_address, bus_error);
    end
  endtask

  task automatic test_reset_in_wait;
    obs_t o;
    IR = mk(7'b0000011, 5'd7, 3'b010, 17'h0); ALU_in = 32'h0000_3000; valid_in = 1'b1;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({mem_req, stall_out} !== 2'b11) begin
      n_miss++; $display("FAIL wait_before_rst got req=%b stall=%b expected 1/1", mem_req, stall_out);
    end
    rst = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ((|{mem_req, mem_we, mem_be, mem_addr, mem_wdata, WB_address, WB_data,
           misaligned, bus_error, stall_out}) !== 1'b0) begin
      n_miss++; $display("FAIL rst_in_wait got req=%b we=%b be=%h addr=%h wba=%0d berr=%b stall=%b expected all 0",
                         mem_req, mem_we, mem_be, mem_addr, WB_address, bus_error, stall_out);
    end
    rst = 1'b0;
    run_instr(mk(7'b0010011, 5'd3, 3'b000, 17'h1A5), 32'h0000_0055, 32'h0, 32'h0, 32'h0, -1, o);
    n_vec++;
    if ({o.wba, o.wbd, o.stall} !== {5'd3, 32'h0000_0055, 32'd0}) begin
      n_miss++; $display("FAIL addi_after_rst got %0d/%h stall=%0d expected 3/00000055/0", o.wba, o.wbd, o.stall);
    end
  endtask

  task automatic test_back_to_back;
    obs_t e;
    logic [6:0] ops [6] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b1101111, 7'b1100111, 7'b1100011};
    logic v;
    for (int i = 0; i < 24; i++) begin
      IR = mk(ops[$urandom_range(0, 5)], 5'($urandom), 3'($urandom), 17'($urandom));
      ALU_in = $urandom; PC = $urandom; B_in = $urandom;
      v = ($urandom_range(0, 4) != 0);
      valid_in = v;
      e = model(IR, ALU_in, B_in, PC, 32'h0, -1);
      if (!v) begin e.wba = 5'd0; e.wbd = 32'd0; end
      #1;
      n_vec++;
      if (stall_out !== 1'b0) begin
        n_miss++; $display("FAIL b2b_stall[%0d] got %b expected 0", i, stall_out);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({WB_address, WB_data} !== {e.wba, e.wbd}) begin
        n_miss++; $display("FAIL b2b_wb[%0d] got %0d/%h expected %0d/%h", i, WB_address, WB_data, e.wba, e.wbd);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_random;
    obs_t o, e;
    logic [6:0] unk [4] = '{7'b1111111, 7'b0001111, 7'b1110011, 7'b0000000};
    logic [2:0] ldf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] ir, alu, b, pc, rdata;
    int k, ack_at, al;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      f3 = 3'($urandom);
      case (k)
        0: op = 7'b0010011;
        1: op = 7'b0110011;
        2: op = ($urandom_range(0, 1) != 0) ? 7'b0110111 : 7'b0010111;
        3: op = 7'b1101111;
        4: op = 7'b1100111;
        5: op = 7'b1100011;
        6: op = unk[$urandom_range(0, 3)];
        7, 8: begin op = 7'b0000011; f3 = ldf[$urandom_range(0, 4)]; end
        default: begin op = 7'b0100011; f3 = 3'($urandom_range(0, 2)); end
      endcase
      ir = mk(op, 5'($urandom), f3, 17'($urandom));
      alu = $urandom; b = $urandom; pc = $urandom; rdata = $urandom;
      al = $urandom_range(0, 3);
      if (al == 0) alu[1:0] = 2'b00;
      else if (al == 1) alu[1:0] = 2'b10;
      ack_at = $urandom_range(0, 6) - 1;
      e = model(ir, alu, b, pc, rdata, ack_at);
      run_instr(ir, alu, b, pc, rdata, ack_at, o);
      n_vec++;
      if ({o.stall, o.req} !== {e.stall, e.req}) begin
        n_miss++; $display("FAIL rand_hs[%0d] ir=%h got stall=%0d req=%0d expected %0d/%0d",
                           i, ir, o.stall, o.req, e.stall, e.req);
      end
      n_vec++;
      if ({o.wba, o.wbd} !== {e.wba, e.wbd}) begin
        n_miss++; $display("FAIL rand_wb[%0d] ir=%h alu=%h got %0d/%h expected %0d/%h",
                           i, ir, alu, o.wba, o.wbd, e.wba, e.wbd);
      end
      n_vec++;
      if ({o.mis, o.berr, o.req_after, o.stable, o.bad_wb} !== {e.mis, e.berr, e.req_after, e.stable, e.bad_wb}) begin
        n_miss++; $display("FAIL rand_flags[%0d] ir=%h got mis/berr/req/stable/badwb=%b%b%b%b%b expected %b%b%b%b%b",
                           i, ir, o.mis, o.berr, o.req_after, o.stable, o.bad_wb,
                           e.mis, e.berr, e.req_after, e.stable, e.bad_wb);
      end
      if (e.req > 0) begin
        n_vec++;
        if ({o.addr, o.we, o.be} !== {e.addr, e.we, e.be} || (e.we && o.wdata !== e.wdata)) begin
          n_miss++; $display("FAIL rand_bus[%0d] ir=%h got addr=%h we=%b be=%b wd=%h expected %h/%b/%b/%h",
                             i, ir, o.addr, o.we, o.be, o.wdata, e.addr, e.we, e.be, e.wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_lb_lbu();
    test_sh_delayed();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog run did not complete within time limit (vectors=%0d miscompares=%0d)", n_vec, n_miss);
    $fatal(1);
  end

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Memory-access / write-back stage of the flat RISC-V pipeline; sits after the execute stage.
- Generates the register-file write port `WB_address`/`WB_data` consumed by the register-read stage, which writes every cycle unconditionally.
- Performs loads and stores over a req/ack data-memory handshake and stalls upstream while an access is outstanding.
- When nothing is written, `WB_address` is driven to 0, so the write lands on x0 and is harmless.

Parameters:
- TIMEOUT_CYCLES, 255: max `WAIT` cycles before an access is aborted; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- IR  input  32  instruction (opcode IR[6:0], rd IR[11:7], funct3 IR[14:12]).
- ALU_in  input  32  execute result; effective address for loads/stores.
- B_in  input  32  rs2 value (store data).
- PC  input  32  instruction PC.
- valid_in  input  1  inputs hold a real instruction.
- stall_out  output  1  combinational; upstream holds all inputs while high.
- mem_req  output  1  access request (registered).
- mem_we  output  1  1 = store.
- mem_addr  output  32  word-aligned address, ALU_in & ~3.
- mem_wdata  output  32  store data, lane-replicated.
- mem_be  output  4  byte enables.
- mem_rdata  input  32  load data, valid with mem_ack.
- mem_ack  input  1  access complete; sampled only in `WAIT`.
- WB_address  output  5  destination register, 0 = no write.
- WB_data  output  32  write-back value.
- misaligned  output  1  one-cycle pulse: misaligned access dropped.
- bus_error  output  1  one-cycle pulse: access timed out.

Behaviour:
- Reset: state = `IDLE`. mem_req, mem_we, mem_be, WB_address, WB_data, misaligned, bus_error, timeout counter all 0; mem_addr and mem_wdata 0. Reset in `WAIT` abandons the access; mem_req is 0 from the cycle after the reset edge.
- States:
  - `IDLE`: no access outstanding.
  - `WAIT`: request issued, waiting for mem_ack or timeout.
- Consumption rule: an instruction is consumed at a posedge where valid_in=1 and stall_out=0.
- stall_out = (`IDLE` & valid_in & is_mem & aligned) | (`WAIT` & ~mem_ack & ~timeout_hit).
- Write-back values for non-memory instructions in `IDLE` (registered; appear the cycle after consumption):
  - LUI, AUIPC, OP (0110011), OP-IMM: WB_data = ALU_in, WB_address = rd.
  - JAL, JALR: WB_data = PC + 4 (mod 2^32), WB_address = rd.
  - BRANCH, unknown opcode, or valid_in=0: WB_address = 0, WB_data = 0 (bubble).
- Memory instruction, aligned, in `IDLE` at posedge:
  - Latch funct3, rd, ALU_in[1:0], mem_we, mem_addr, mem_be, mem_wdata; set mem_req = 1; go to `WAIT`.
  - WB_address = 0 for that cycle.
- In `WAIT`:
  - mem_req and all mem_* outputs held stable; counter increments each cycle.
  - On mem_ack: next posedge clears mem_req and returns to `IDLE`. For loads, WB_address = rd and WB_data = extracted load data; for stores, WB_address = 0.
- Load extraction, lane = addr[1:0]:
  - LB: sign-extended byte lane.
  - LBU: zero-extended byte lane.
  - LH: sign-extended half at addr[1].
  - LHU: zero-extended half at addr[1].
  - LW: full word.
- Store enables and data:
  - SB: be = 1 << addr[1:0], wdata = {4{B[7:0]}}.
  - SH: be = 4'b0011 << addr[1:0], wdata = {2{B[15:0]}}.
  - SW: be = 4'b1111, wdata = B.
- Alignment:
  - Halfword with addr[0]=1, or word with addr[1:0] != 0, is misaligned.
  - Misaligned access: no request, no stall; misaligned = 1 for one cycle; WB_address = 0.
- Timeout:
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with no ack: clear mem_req, return to `IDLE`, bus_error = 1 for one cycle, WB_address = 0.
  - stall_out drops in the hit cycle, so the instruction is consumed.
  - If mem_ack and timeout hit in the same cycle, mem_ack wins.
- mem_ack in `IDLE` is ignored.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Load: WB valid 2 cycles after acceptance when ack arrives in the first `WAIT` cycle.
  - Throughput: one instruction per cycle when no memory access is outstanding.

Test Plan:
- JAL, rd=1, PC=0x00000100, valid_in=1 -> next cycle WB_address=1, WB_data=0x00000104, stall_out=0 throughout.
- LB, ALU_in=0x00001003, ack in first `WAIT` cycle with rdata=0x80FF1234 -> mem_addr=0x00001000, be=4'b1111 ignored for reads, WB_data=0xFFFFFF80; repeat as LBU -> 0x00000080.
- SH, ALU_in=0x00002002, B=0x0000ABCD, ack delayed 3 cycles -> mem_we=1, be=4'b1100, wdata=0xABCDABCD held stable 4 `WAIT` cycles, stall_out high until the ack cycle, WB_address=0.
- LW, ALU_in=0x00001001 -> no mem_req, misaligned pulses 1 cycle, WB_address=0, no stall.
- TIMEOUT_CYCLES=4, load, no ack -> mem_req high 4 cycles then low, bus_error pulse, state `IDLE`; spurious ack afterwards ignored.
- rst asserted in second `WAIT` cycle of a load -> mem_req=0 and all outputs 0 next cycle, stall_out=0; subsequent ADDI writes back normally.
